// File: rtl/lut_pkg.sv
// Shared definitions for the increment lookup table: writer state encoding,
// default geometry and the default fill pattern used by writer, readers and models.
package lut_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } lut_state_e;

  localparam int LUT_LOG2_WIDTH = 3;
  localparam int LUT_WIDTH      = 2 ** LUT_LOG2_WIDTH;

  // Default entry j holds j+1, truncated to the entry width.
  function automatic logic [31:0] default_entry(input logic [31:0] j, input int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (j + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/lut_ram.sv
// WIDTH x WIDTH register table with one synchronous write port and one
// registered read-before-write read port.
module lut_ram
  import lut_pkg::*;
#(
  parameter int LOG2_WIDTH = LUT_LOG2_WIDTH,
  parameter int WIDTH      = 2 ** LOG2_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_we,
  input  logic [LOG2_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [LOG2_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  logic [WIDTH-1:0] r_mem [WIDTH];
  logic [WIDTH-1:0] r_rd_data;

  // Storage is never reset; a write presented while reset is asserted is dropped.
  always_ff @(posedge clock) begin
    if (i_we && reset_n) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register samples the pre-write contents, so a same-edge write shows up one cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lut_writer.sv
// Write-side owner of the increment lookup table: default fill sweep after reset
// or on request, then valid/ready entry updates; registered read port for consumers.
module lut_writer
  import lut_pkg::*;
#(
  parameter int LOG2_WIDTH = LUT_LOG2_WIDTH,
  parameter int WIDTH      = 2 ** LOG2_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_init_req,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [LOG2_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [LOG2_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic                  o_busy,
  output logic                  o_strobe,
  output logic                  o_done
);

  localparam logic [LOG2_WIDTH-1:0] PTR_LAST = LOG2_WIDTH'(WIDTH - 1);

  lut_state_e            r_state;
  lut_state_e            w_state_nxt;
  logic [LOG2_WIDTH-1:0] r_ptr;
  logic [LOG2_WIDTH-1:0] w_ptr_nxt;
  logic                  r_wr_ready;
  logic                  r_busy;
  logic                  r_strobe;
  logic                  r_done;
  logic                  w_we;
  logic                  w_wr_fire;
  logic                  w_sweep_last;
  logic [LOG2_WIDTH-1:0] w_wr_addr;
  logic [WIDTH-1:0]      w_wr_data;

  // Next state, sweep pointer and table write mux.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_we         = 1'b0;
    w_wr_fire    = 1'b0;
    w_sweep_last = 1'b0;
    w_wr_addr    = r_ptr;
    w_wr_data    = WIDTH'(default_entry(32'(r_ptr), WIDTH));
    case (r_state)
      ST_INIT: begin
        w_we         = 1'b1;
        w_sweep_last = (r_ptr == PTR_LAST);
        if (w_sweep_last) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_state_nxt = ST_INIT;
          w_ptr_nxt   = r_ptr + LOG2_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        // An accepted write still commits when init_req arrives; the sweep overwrites it later.
        w_wr_fire = i_wr_valid && r_wr_ready;
        w_we      = w_wr_fire;
        w_wr_addr = i_wr_addr;
        w_wr_data = i_wr_data;
        w_ptr_nxt = '0;
        if (i_init_req) begin
          w_state_nxt = ST_INIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // State, pointer and registered status outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_INIT;
      r_ptr      <= '0;
      r_wr_ready <= 1'b0;
      r_busy     <= 1'b1;
      r_strobe   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_wr_ready <= (w_state_nxt == ST_IDLE);
      r_busy     <= (w_state_nxt == ST_INIT);
      r_strobe   <= w_wr_fire;
      r_done     <= w_sweep_last;
    end
  end

  lut_ram #(
    .LOG2_WIDTH(LOG2_WIDTH),
    .WIDTH     (WIDTH)
  ) u_ram (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_we     (w_we),
    .i_wr_addr(w_wr_addr),
    .i_wr_data(w_wr_data),
    .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data)
  );

  assign o_wr_ready = r_wr_ready;
  assign o_busy     = r_busy;
  assign o_strobe   = r_strobe;
  assign o_done     = r_done;

endmodule

// File: tb/tb_lut_writer.sv
// Bench for lut_writer: behavioural table model with per-cycle comparison,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lut_writer;

  localparam int LW = 3;
  localparam int W  = 8;

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b1;
  logic          init_req = 1'b0;
  logic          wr_valid = 1'b0;
  logic [LW-1:0] wr_addr  = '0;
  logic [W-1:0]  wr_data  = '0;
  logic [LW-1:0] rd_addr  = '0;
  logic          wr_ready;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          strobe;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  lut_writer #(.LOG2_WIDTH(LW), .WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_init_req(init_req),
    .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data),
    .o_busy    (busy),
    .o_strobe  (strobe),
    .o_done    (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table contents, which entries hold defined data, and the
  // number of sweep writes still outstanding (zero means the write port is open).
  logic [W-1:0] m_mem [W];
  bit           m_known [W];
  int           m_left     = W;
  bit           m_strobe   = 1'b0;
  bit           m_done     = 1'b0;
  logic [W-1:0] m_rd       = '0;
  bit           m_rd_known = 1'b1;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_left     <= W;
      m_strobe   <= 1'b0;
      m_done     <= 1'b0;
      m_rd       <= '0;
      m_rd_known <= 1'b1;
    end else begin
      m_rd       <= m_mem[rd_addr];
      m_rd_known <= m_known[rd_addr];
      if (m_left > 0) begin
        m_mem[W - m_left]   <= 8'((W - m_left + 1) % 256);
        m_known[W - m_left] <= 1'b1;
        m_left              <= m_left - 1;
        m_done              <= (m_left == 1);
        m_strobe            <= 1'b0;
      end else begin
        m_done   <= 1'b0;
        m_strobe <= wr_valid;
        if (wr_valid) begin
          m_mem[wr_addr]   <= wr_data;
          m_known[wr_addr] <= 1'b1;
        end
        if (init_req) begin
          m_left <= W;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    check("wr_ready", 32'(wr_ready), 32'(m_left == 0));
    check("busy", 32'(busy), 32'(m_left != 0));
    check("strobe", 32'(strobe), 32'(m_strobe));
    check("done", 32'(done), 32'(m_done));
    if (m_rd_known) begin
      check("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  pend;
    pend = 1'b0;

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Initial sweep: done must arrive on edge 8 after release.
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("reset_done_edge", n, 8);

    for (int k = 0; k < W; k++) begin
      rd_addr = 3'(k);
      @(negedge clock);
      check("default_rd", 32'(rd_data), k + 1);
    end

    // Single write to entry 5.
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 8'hA5; rd_addr = 3'd5;
    @(negedge clock);
    wr_valid = 1'b0;
    check("wr5_strobe", 32'(strobe), 1);
    check("wr5_old", 32'(rd_data), 6);
    @(negedge clock);
    check("wr5_new", 32'(rd_data), 32'h0000_00A5);
    rd_addr = 3'd4;
    @(negedge clock);
    check("rd4_untouched", 32'(rd_data), 5);

    // Same-edge read and write of entry 2.
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 8'h55; rd_addr = 3'd2;
    @(negedge clock);
    wr_valid = 1'b0;
    check("rbw_old", 32'(rd_data), 3);
    @(negedge clock);
    check("rbw_new", 32'(rd_data), 32'h0000_0055);

    // Eight back-to-back writes.
    for (int k = 0; k < W; k++) begin
      wr_valid = 1'b1; wr_addr = 3'(k); wr_data = 8'(8'hF0 + k);
      @(negedge clock);
      check("b2b_strobe", 32'(strobe), 1);
    end
    wr_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      rd_addr = 3'(k);
      @(negedge clock);
      check("b2b_rd", 32'(rd_data), 32'hF0 + k);
    end

    // init_req together with a write; a held write during the sweep must wait.
    init_req = 1'b1; wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'h77;
    @(negedge clock);
    init_req = 1'b0; wr_addr = 3'd6; wr_data = 8'h11;
    check("init_wr_strobe", 32'(strobe), 1);
    check("init_busy", 32'(busy), 1);
    check("init_ready", 32'(wr_ready), 0);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("init_done_edge", n, 8);
    rd_addr = 3'd3;
    @(negedge clock);
    check("held_wr_accept", 32'(strobe), 1);
    check("rd3_after_sweep", 32'(rd_data), 4);
    wr_valid = 1'b0;
    rd_addr = 3'd6;
    @(negedge clock);
    check("rd6_held_wr", 32'(rd_data), 32'h0000_0011);

    // Reset pulse in the middle of a sweep.
    init_req = 1'b1;
    @(negedge clock);
    init_req = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_ready", 32'(wr_ready), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_strobe", 32'(strobe), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd", 32'(rd_data), 0);
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("rst_done_edge", n, 8);
    for (int k = 0; k < W; k++) begin
      rd_addr = 3'(k);
      @(negedge clock);
      check("rst_default_rd", 32'(rd_data), k + 1);
    end

    // Randomized traffic; a pending write holds address and data until accepted.
    for (int c = 0; c < 800; c++) begin
      if (pend && m_strobe) begin
        pend = 1'b0;
      end
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend    = 1'b1;
        wr_addr = 3'($urandom);
        wr_data = 8'($urandom);
      end
      wr_valid = pend;
      rd_addr  = 3'($urandom);
      init_req = ($urandom_range(0, 39) == 0);
      @(negedge clock);
    end
    wr_valid = 1'b0;
    init_req = 1'b0;
    repeat (12) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_writer.md
# lut_writer

Write-side owner of the increment lookup table: holds a WIDTH-entry × WIDTH-bit register array, fills it with the default pattern entry[j] = j+1 after reset, and then accepts run-time entry updates over a valid/ready port. A registered read port serves the table to downstream lookup logic with one-cycle latency. The block sits beside the table consumers and is the only agent allowed to modify table contents.

## Interface
- LOG2_WIDTH, 3, log2 of table depth and entry width
- WIDTH, 2**LOG2_WIDTH, number of entries and bits per entry
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous, active-low
- init_req  in  1  request to rerun the default fill sweep; sampled in IDLE only
- wr_valid  in  1  write request valid
- wr_ready  out  1  write port can accept; registered state decode
- wr_addr  in  LOG2_WIDTH  entry index to write
- wr_data  in  WIDTH  entry value
- rd_addr  in  LOG2_WIDTH  entry index to read
- rd_data  out  WIDTH  registered table entry at rd_addr
- busy  out  1  fill sweep in progress
- strobe  out  1  one-cycle pulse: one write committed
- done  out  1  one-cycle pulse: fill sweep completed

## Operation
- States: INIT, IDLE. Reset forces INIT with sweep pointer 0.
- INIT: each cycle write entry[ptr] = (ptr+1) truncated to WIDTH bits, ptr increments; after ptr = WIDTH-1 is written, go to IDLE. Every entry including WIDTH-1 is filled (entry[WIDTH-1] = WIDTH).
- IDLE: wr_ready = 1. Handshake: write occurs when wr_valid && wr_ready at a rising edge; entry[wr_addr] <= wr_data on that edge.
- init_req high in IDLE: go to INIT next edge. If a write is accepted in the same cycle, it is committed, then overwritten by the sweep.
- init_req in INIT: ignored (sweep not restarted).
- wr_valid in INIT: not accepted (wr_ready = 0); requester holds wr_addr/wr_data until accepted.
- Read port independent of state: rd_data <= entry[rd_addr] every edge, including during INIT.
- Same-address read and write on one edge: read-before-write; rd_data shows the old value, the new value one cycle later.
- Array contents are not reset; only the sweep defines them. Reads during a sweep return the not-yet-overwritten contents.

## Timing
- Reset values: wr_ready 0, busy 1, strobe 0, done 0, rd_data 0, state INIT, ptr 0.
- Sweep length: WIDTH cycles. Edge 1 after reset release writes entry 0, edge WIDTH writes entry WIDTH-1 and enters IDLE; from then wr_ready = 1, busy = 0, done = 1 for exactly one cycle.
- Write latency: entry visible to a read issued on the cycle after the accepting edge; strobe high for the cycle following the accepting edge.
- Back-to-back writes: one per cycle sustained in IDLE.
- init_req sampled at edge E in IDLE: busy = 1 and wr_ready = 0 from E; sweep completes at E+WIDTH, done high after it.
- reset_n asserted mid-sweep or mid-write: outputs take reset values immediately; sweep restarts from entry 0 after release; a write on the reset edge is lost.

## Structure
- Shared package lut_pkg: state encoding (ST_INIT, ST_IDLE), function default_entry(j) returning (j+1) truncated to WIDTH bits, for reuse by table readers and the bench model.
- Sub-module lut_ram: WIDTH × WIDTH register array, one synchronous write port, one registered read port with read-before-write; lut_writer holds the FSM, sweep pointer, write mux, and pulses.

## Test plan
- Release reset, rd_addr swept 0..7 after done -> rd_data = 1,2,...,8; done high exactly one cycle, at edge 8 after release; wr_ready low until then.
- In IDLE, write addr 5 data 8'hA5 -> strobe one cycle later, rd_addr 5 gives 8'hA5; addr 4 still 5.
- Eight back-to-back writes addr k data 8'hF0+k, wr_valid held high -> all accepted in 8 cycles, readback F0..F7.
- Same-cycle write addr 2 data 8'h55 and read addr 2 -> rd_data 3 then 8'h55 next cycle.
- init_req with simultaneous write addr 3 data 8'h77 -> write strobes, busy for 8 cycles, addr 3 reads 4 after done; wr_valid during sweep not accepted.
- reset_n pulsed low at sweep step 4 -> outputs at reset values at once; full 8-cycle sweep after release, table equals default.
